uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

UART receiver for the serial command path: deserialises 8N1 frames from the board's RX pin into single bytes with a one-cycle `valid` strobe. It sits directly upstream of the keyword matcher, whose `valid`/`data_in` inputs it drives. It also reports framing errors and a busy flag for the display and status logic.

## Interface

- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `BIT_CNT` (localparam) = `CLK_FREQ/BAUD` (integer division; 10416 at defaults).
- `HALF_CNT` (localparam) = `BIT_CNT/2` (5208 at defaults).

Ports:

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rxd`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `valid`  out  1  one-cycle pulse: `data` holds a newly received byte.
- `data`  out  8  last received byte; held until the next `valid`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation

- **Synchroniser**
  - `rxd` passes through a 2-flop synchroniser, giving `rx_s`.
  - A third flop `rx_d` holds the previous `rx_s`.
  - All three flops reset to 1.
  - A falling edge is `rx_d==1 && rx_s==0`.
- **Counters**
  - Baud counter: `$clog2(BIT_CNT)` bits. It reloads to 0 on every state entry and on every sample point.
  - Bit index: 3 bits, for data bits 0..7.
- **IDLE**
  - Waits for a falling edge on `rx_s`, then goes to START.
- **START**
  - Counts to `HALF_CNT-1`, then samples `rx_s` at mid start bit.
  - `rx_s==0`: go to DATA with bit index 0.
  - `rx_s==1`: glitch. Return to IDLE silently, with no `frame_err`.
- **DATA**
  - Each time the counter reaches `BIT_CNT-1`, sample `rx_s` into the shift register, LSB first.
  - After bit 7, go to STOP.
- **STOP**
  - At `BIT_CNT-1`, sample `rx_s`.
  - `rx_s==1`: load `data` from the shift register, pulse `valid`, go to IDLE.
  - `rx_s==0`: pulse `frame_err`, leave `data` unchanged, go to BREAK.
- **BREAK**
  - Waits until `rx_s==1`, then goes to IDLE.
  - This prevents a held-low line from producing repeated frames.
- **Default/illegal state:** go to IDLE.
- **Outputs**
  - `valid` and `frame_err` are registered and never high together.
  - `busy = (state != IDLE)`, registered or decoded from state.
- **Reset mid-frame:** immediate abort. FSM goes to IDLE, the partial byte is discarded, and no `valid` or `frame_err` is produced.

## Timing

- **Reset values:** `valid`=0, `data`=8'h00, `frame_err`=0, `busy`=0, state=IDLE, counters=0.
- **Edge detection:** let E be the clk edge at which the falling edge is detected. E is 2–3 cycles after the `rxd` transition, due to the synchroniser.
- **Start sample:** at E+HALF_CNT.
- **Data bit k (0..7):** sampled at E+HALF_CNT+(k+1)·BIT_CNT.
- **Stop bit:** sampled at E+HALF_CNT+9·BIT_CNT. `valid` or `frame_err` is high for exactly the following cycle.
- **Latency:** about 9.5 bit times from the start-bit falling edge to `valid`; 989 µs at default parameters.
- **Back-to-back frames:**
  - IDLE is re-entered at mid stop bit, so a start bit directly after the stop bit is caught.
  - The second half of the stop bit is high, so it cannot create a false edge.
- **Clock tolerance:** mid-bit sampling tolerates ±4% cumulative clock/baud mismatch over 10 bits.
- **`data` stability:** `data` changes only on the cycle `valid` rises. The downstream matcher may sample it in the `valid` cycle or any later cycle.

## Test plan

- **Single byte:** drive 0x73 ('s') at 9600 baud after reset -> exactly one `valid` pulse, `data`=8'h73, `frame_err` never asserted, `busy` low again after the pulse.
- **Back-to-back bytes:** drive "stop" (0x73, 0x74, 0x6F, 0x70) with zero idle gap -> four `valid` pulses spaced 10·BIT_CNT ±3 cycles apart, with `data` values in order.
- **Glitch rejection:** pulse `rxd` low for 1000 cycles -> no `valid`, no `frame_err`, FSM back in IDLE by about E+HALF_CNT+1.
- **Framing error:** send 0x68 with the stop bit driven low, then hold low for 3 bit times, then release -> one `frame_err` pulse, no `valid`, `data` keeps its prior value, `busy` stays high until the line is high. A following 0x69 is received correctly.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xA5, then send 0x3C -> no output for 0xA5, `valid` with `data`=8'h3C.
- **Baud skew:** send 0x55 and 0xFF at 9600·1.03 and 9600·0.97 -> both bytes received correctly at both rates.

Source files
------------

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART receiver producing one byte per valid strobe
//
// Purpose: deserialises 8N1 frames from an asynchronous RX pin into bytes.
//   It samples at mid-bit, using a start-bit timer and a per-bit timer.
//   It rejects glitches on the start bit.
//   It reports framing errors, then holds off until the line goes idle.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   rxd        in   1  raw serial line, idle high, asynchronous to clk
//   valid      out  1  one-cycle pulse, data holds a new byte
//   data       out  8  last good byte, held until the next valid
//   frame_err  out  1  one-cycle pulse, stop bit sampled low
//   busy       out  1  high while the receiver is not idle

module uart_byte_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic rx_meta;
  logic rx_s;
  logic rx_d;
  logic fall;

  // Two-flop synchroniser plus one history flop for edge detection.
  // All three flops reset high, so that leaving reset on an idle line
  // cannot look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (fall) begin
            state <= S_START;
          end
        end

        // Half a bit after the edge: a line that is high again was a glitch.
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // LSB arrives first, so shift in from the top.
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Return to IDLE at mid stop bit, so that a start bit directly
        // after the stop bit is still seen.
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Hold off while the line stays low, so that a break condition
        // reports one error and not a stream of bogus frames.
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - self-checking bench for uart_byte_rx

module tb_uart_byte_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_T    = 1000;  // 100 clocks of 10 time units each

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       valid;
  logic [7:0] data;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bit_t;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  exp_t       sb[$];
  int         vtimes[$];
  logic [7:0] hold;
  vec_t       vecs[10];

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .valid     (valid),
    .data      (data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_t);
    rxd = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_t);
    end
    rxd = stop_bit;
    #(bit_t);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: pops an expectation for every output pulse and
  // checks that data stays put between pulses.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 8'h00;
    end else begin
      if (valid && frame_err) begin
        total++;
        bad++;
        $display("FAIL both_pulses valid=%0b frame_err=%0b required=not_both", valid, frame_err);
      end
      if (valid || frame_err) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output valid=%0b frame_err=%0b data=%02h required=none", valid, frame_err, data);
        end else begin
          e = sb.pop_front();
          if (valid !== !e.is_err || frame_err !== e.is_err ||
              data !== (e.is_err ? hold : e.data)) begin
            bad++;
            $display("FAIL rx_result valid=%0b err=%0b data=%02h required err=%0b data=%02h",
                     valid, frame_err, data, e.is_err, e.is_err ? hold : e.data);
          end
          if (!e.is_err) hold = e.data;
        end
        if (valid) vtimes.push_back(cyc);
      end else begin
        total++;
        if (data !== hold) begin
          bad++;
          $display("FAIL data_hold actual=%02h required=%02h", data, hold);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h73, 1'b1, BIT_T, 1'b0, 8'h73};
    vecs[1] = '{8'h00, 1'b1, BIT_T, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, BIT_T, 1'b0, 8'hFF};
    vecs[3] = '{8'h80, 1'b1, BIT_T, 1'b0, 8'h80};
    vecs[4] = '{8'h01, 1'b1, BIT_T, 1'b0, 8'h01};
    vecs[5] = '{8'h55, 1'b1, 971,   1'b0, 8'h55};
    vecs[6] = '{8'hFF, 1'b1, 971,   1'b0, 8'hFF};
    vecs[7] = '{8'h55, 1'b1, 1031,  1'b0, 8'h55};
    vecs[8] = '{8'hFF, 1'b1, 1031,  1'b0, 8'hFF};
    vecs[9] = '{8'h5A, 1'b0, BIT_T, 1'b1, 8'h00};

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", 32'(data), 32'h00);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #(2 * BIT_T);

    // Table-driven frames: nominal rate, skewed rates, and one framing error
    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].exp_err, vecs[i].exp_data});
      send_byte(vecs[i].data, vecs[i].stop, vecs[i].bit_t);
      rxd = 1'b1;
      wait_drain("vec");
      #(2 * BIT_T);
      check("vec_busy_idle", 32'(busy), 32'd0);
    end

    // Back-to-back "stop" with no idle gap
    vtimes.delete();
    sb.push_back('{1'b0, 8'h73});
    sb.push_back('{1'b0, 8'h74});
    sb.push_back('{1'b0, 8'h6F});
    sb.push_back('{1'b0, 8'h70});
    send_byte(8'h73, 1'b1, BIT_T);
    send_byte(8'h74, 1'b1, BIT_T);
    send_byte(8'h6F, 1'b1, BIT_T);
    send_byte(8'h70, 1'b1, BIT_T);
    wait_drain("b2b");
    check("b2b_count", 32'(vtimes.size()), 32'd4);
    for (int i = 1; i < vtimes.size(); i++) begin
      int d;
      d = vtimes[i] - vtimes[i-1];
      check("b2b_spacing_ok", 32'(d >= 997 && d <= 1003), 32'd1);
    end
    #(2 * BIT_T);

    // Glitch shorter than half a bit is dropped
    rxd = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("glitch_busy_high", 32'(busy), 32'd1);
    repeat (20) @(posedge clk);
    rxd = 1'b1;
    repeat (28) @(posedge clk);
    #1;
    check("glitch_busy_low", 32'(busy), 32'd0);
    #(2 * BIT_T);

    // Framing error followed by a held-low line, then a good byte
    sb.push_back('{1'b1, 8'h00});
    send_byte(8'h68, 1'b0, BIT_T);
    #(2 * BIT_T);
    check("ferr_busy_in_break", 32'(busy), 32'd1);
    check("ferr_data_kept", 32'(data), 32'(hold));
    #(BIT_T);
    rxd = 1'b1;
    wait_drain("ferr");
    repeat (10) @(posedge clk);
    #1;
    check("ferr_busy_released", 32'(busy), 32'd0);
    #(BIT_T);
    sb.push_back('{1'b0, 8'h69});
    send_byte(8'h69, 1'b1, BIT_T);
    wait_drain("after_ferr");
    #(2 * BIT_T);

    // Reset in the middle of data bit 4 of 0xA5; released during stop bit
    fork
      send_byte(8'hA5, 1'b1, BIT_T);
      begin
        #(5 * BIT_T + BIT_T / 2);
        rst = 1'b1;
        #20;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_data", 32'(data), 32'h00);
        #(4 * BIT_T);
        rst = 1'b0;
      end
    join
    rxd = 1'b1;
    #(BIT_T);
    sb.push_back('{1'b0, 8'h3C});
    send_byte(8'h3C, 1'b1, BIT_T);
    wait_drain("after_rst");
    #(2 * BIT_T);
    check("final_data", 32'(data), 32'h3C);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
